// File: rtl/phy_rx_deframer_pkg.sv
// Shared constants for the PHY receive deframer: start-of-packet marker,
// FSM state encodings, error codes and parameter defaults.
package phy_rx_deframer_pkg;

  localparam logic [7:0] SOP = 8'hFB;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_CHECK   = 2'd2;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam int MAX_LEN_DEF = 16;
  localparam int TIMEOUT_DEF = 8;

  function automatic logic is_sop(input logic [31:0] word);
    return (word[31:24] == SOP);
  endfunction

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/phy_rx_deframer_xor_acc.sv
// 32-bit running XOR of payload words; clear wins over enable so a new
// header always starts from zero.
module xor_acc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 32'h0000_0000;
    end else if (clr) begin
      q <= 32'h0000_0000;
    end else if (en) begin
      q <= q ^ d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/phy_rx_deframer.sv
// Receive deframer: finds {FB, tag, len} headers, forwards len payload words
// with sop/eop, then validates the XOR check word, with idle-gap timeout.
module phy_rx_deframer
  import phy_rx_deframer_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clock4,
  input  logic        reset_L,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic [31:0] pkt_data,
  output logic        pkt_valid,
  output logic        pkt_sop,
  output logic        pkt_eop,
  output logic [15:0] pkt_tag,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [7:0]  good_cnt,
  output logic [7:0]  err_cnt
);

  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  logic [1:0]  state_r;
  logic [7:0]  rem_r;
  logic        first_r;
  logic [15:0] idle_r;

  logic [31:0] acc_q_s;
  logic        hdr_s;
  logic        len_ok_s;
  logic        abort_s;
  logic        acc_clr_s;
  logic        acc_en_s;
  logic        csum_ok_s;
  logic [15:0] idle_next_s;

  // Header decode, idle-timeout detection and accumulator controls.
  always_comb begin
    hdr_s       = is_sop(data_in);
    len_ok_s    = (data_in[7:0] != 8'd0) && (data_in[7:0] <= MAX_LEN_B);
    idle_next_s = idle_r + 16'd1;
    abort_s     = (state_r != ST_IDLE) && !valid_in && (idle_next_s >= TIMEOUT_W);
    acc_clr_s   = valid_in && (state_r == ST_IDLE) && hdr_s && len_ok_s;
    acc_en_s    = valid_in && (state_r == ST_PAYLOAD);
    csum_ok_s   = (data_in == acc_q_s);
  end

  xor_acc u_xor_acc (
    .clk   (clock4),
    .rst_n (reset_L),
    .clr   (acc_clr_s),
    .en    (acc_en_s),
    .d     (data_in),
    .q     (acc_q_s)
  );

  // Deframing FSM with registered outputs and event counters.
  always_ff @(posedge clock4 or negedge reset_L) begin
    if (!reset_L) begin
      state_r   <= ST_IDLE;
      rem_r     <= 8'd0;
      first_r   <= 1'b0;
      idle_r    <= 16'd0;
      pkt_data  <= 32'h0000_0000;
      pkt_valid <= 1'b0;
      pkt_sop   <= 1'b0;
      pkt_eop   <= 1'b0;
      pkt_tag   <= 16'h0000;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      good_cnt  <= 8'd0;
      err_cnt   <= 8'd0;
    end else begin
      pkt_valid <= 1'b0;
      pkt_sop   <= 1'b0;
      pkt_eop   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      if (abort_s) begin
        // Abandon the packet; words already forwarded stand, but no eop.
        state_r  <= ST_IDLE;
        idle_r   <= 16'd0;
        rem_r    <= 8'd0;
        first_r  <= 1'b0;
        err      <= 1'b1;
        err_code <= ERR_TIMEOUT;
        err_cnt  <= sat_inc(err_cnt);
      end else begin
        case (state_r)
          ST_IDLE: begin
            idle_r <= 16'd0;
            if (valid_in && hdr_s) begin
              if (len_ok_s) begin
                pkt_tag <= data_in[23:8];
                rem_r   <= data_in[7:0];
                first_r <= 1'b1;
                state_r <= ST_PAYLOAD;
              end else begin
                err      <= 1'b1;
                err_code <= ERR_LEN;
                err_cnt  <= sat_inc(err_cnt);
              end
            end
          end
          ST_PAYLOAD: begin
            if (valid_in) begin
              idle_r    <= 16'd0;
              pkt_data  <= data_in;
              pkt_valid <= 1'b1;
              pkt_sop   <= first_r;
              first_r   <= 1'b0;
              pkt_eop   <= (rem_r == 8'd1);
              rem_r     <= rem_r - 8'd1;
              if (rem_r == 8'd1) begin
                state_r <= ST_CHECK;
              end
            end else begin
              idle_r <= idle_next_s;
            end
          end
          ST_CHECK: begin
            if (valid_in) begin
              idle_r  <= 16'd0;
              state_r <= ST_IDLE;
              if (csum_ok_s) begin
                done     <= 1'b1;
                good_cnt <= sat_inc(good_cnt);
              end else begin
                err      <= 1'b1;
                err_code <= ERR_CSUM;
                err_cnt  <= sat_inc(err_cnt);
              end
            end else begin
              idle_r <= idle_next_s;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            idle_r  <= 16'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phy_rx_deframer.sv
// Bench for phy_rx_deframer: directed frames plus randomized traffic checked
// against a packet-level scoreboard of expected words and done/err events.
module tb_phy_rx_deframer;

  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 8;

  logic        clock4 = 1'b0;
  logic        reset_L = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic        valid_in = 1'b0;
  logic [31:0] pkt_data;
  logic        pkt_valid, pkt_sop, pkt_eop, done, err;
  logic [15:0] pkt_tag;
  logic [1:0]  err_code;
  logic [7:0]  good_cnt, err_cnt;

  always #5 clock4 = ~clock4;

  phy_rx_deframer #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clock4(clock4), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
    .pkt_tag(pkt_tag), .done(done), .err(err), .err_code(err_code),
    .good_cnt(good_cnt), .err_cnt(err_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Scoreboard: expected output words {tag, sop, eop, data}, expected events {is_done, code}.
  logic [49:0] exp_words[$];
  logic [2:0]  exp_evt[$];
  int          exp_good = 0;
  int          exp_err  = 0;
  logic [49:0] mon_w;
  logic [2:0]  mon_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_evt(input bit is_done, input logic [1:0] code);
    exp_evt.push_back({is_done, code});
    if (is_done) exp_good = (exp_good < 255) ? exp_good + 1 : 255;
    else         exp_err  = (exp_err  < 255) ? exp_err  + 1 : 255;
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    @(negedge clock4);
    valid_in = v;
    data_in  = d;
  endtask

  task automatic gap(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, $urandom);
  endtask

  task automatic junk(input int n);
    logic [31:0] w;
    for (int k = 0; k < n; k++) begin
      w = $urandom;
      if (w[31:24] == 8'hFB) w[31:24] = 8'h00;
      drive(1'b1, w);
    end
  endtask

  task automatic check_counters(input string tag);
    @(posedge clock4);
    #1;
    check({tag, "_good_cnt"}, 64'(good_cnt), 64'(exp_good));
    check({tag, "_err_cnt"},  64'(err_cnt),  64'(exp_err));
  endtask

  // Sends one frame; a bad length gives only the header, a bad check word flips one bit.
  task automatic send_packet(input logic [15:0] tag, input int len, input bit good, input int max_gap);
    logic [31:0] w;
    logic [31:0] x;
    x = 32'h0;
    drive(1'b1, {8'hFB, tag, 8'(len)});
    if (len < 1 || len > MAX_LEN) begin
      push_evt(1'b0, 2'b01);
    end else begin
      for (int i = 0; i < len; i++) begin
        if (max_gap > 0) gap(int'($urandom_range(max_gap, 0)));
        w = $urandom;
        if ($urandom_range(3, 0) == 0) w[31:24] = 8'hFB;
        exp_words.push_back({tag, 1'(i == 0), 1'(i == len - 1), w});
        x ^= w;
        drive(1'b1, w);
      end
      if (max_gap > 0) gap(int'($urandom_range(max_gap, 0)));
      if (!good) x ^= (32'h1 << $urandom_range(31, 0));
      push_evt(good, good ? 2'b00 : 2'b10);
      drive(1'b1, x);
    end
    drive(1'b0, 32'h0);
  endtask

  // Output monitor: every forwarded word and every done/err pulse must be expected, in order.
  always @(negedge clock4) begin
    if (reset_L) begin
      if (pkt_valid) begin
        if (exp_words.size() == 0) begin
          check("unexpected_word", 64'(exp_words.size()), 64'd1);
        end else begin
          mon_w = exp_words.pop_front();
          check("pkt_word", 64'({pkt_tag, pkt_sop, pkt_eop, pkt_data}), 64'(mon_w));
        end
      end
      if (done || err) begin
        check("done_and_err", 64'(done & err), 64'd0);
        if (exp_evt.size() == 0) begin
          check("unexpected_event", 64'(exp_evt.size()), 64'd1);
        end else begin
          mon_e = exp_evt.pop_front();
          if (mon_e[2]) check("event_done", 64'({done, err}), 64'(2'b10));
          else          check("event_err", 64'({done, err, err_code}), 64'({2'b01, mon_e[1:0]}));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int          len;
    int          r;

    repeat (3) @(negedge clock4);
    #1;
    check("rst_outputs_a", 64'({pkt_data, pkt_valid, pkt_sop, pkt_eop, done, err, err_code}), 64'd0);
    check("rst_outputs_b", 64'({pkt_tag, good_cnt, err_cnt}), 64'd0);
    @(negedge clock4);
    reset_L = 1'b1;
    gap(2);

    // Reference good packet with cycle-exact sop/eop/done checks.
    exp_words.push_back({16'h1234, 1'b1, 1'b0, 32'h11111111});
    exp_words.push_back({16'h1234, 1'b0, 1'b0, 32'h22222222});
    exp_words.push_back({16'h1234, 1'b0, 1'b1, 32'h44444444});
    push_evt(1'b1, 2'b00);
    drive(1'b1, 32'hFB123403);
    drive(1'b1, 32'h11111111);
    @(posedge clock4); #1;
    check("latency_sop", 64'({pkt_valid, pkt_sop, pkt_eop, pkt_tag}), 64'({3'b110, 16'h1234}));
    drive(1'b1, 32'h22222222);
    drive(1'b1, 32'h44444444);
    @(posedge clock4); #1;
    check("eop_third", 64'({pkt_valid, pkt_sop, pkt_eop}), 64'(3'b101));
    drive(1'b1, 32'h77777777);
    @(posedge clock4); #1;
    check("done_pulse", 64'({done, err, pkt_valid}), 64'(3'b100));
    drive(1'b0, 32'h0);
    @(posedge clock4); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check_counters("good_pkt");

    // Same packet with a wrong check word.
    exp_words.push_back({16'h1234, 1'b1, 1'b0, 32'h11111111});
    exp_words.push_back({16'h1234, 1'b0, 1'b0, 32'h22222222});
    exp_words.push_back({16'h1234, 1'b0, 1'b1, 32'h44444444});
    push_evt(1'b0, 2'b10);
    drive(1'b1, 32'hFB123403);
    drive(1'b1, 32'h11111111);
    drive(1'b1, 32'h22222222);
    drive(1'b1, 32'h44444444);
    drive(1'b1, 32'h77777770);
    @(posedge clock4); #1;
    check("csum_err", 64'({done, err, err_code}), 64'(4'b0110));
    drive(1'b0, 32'h0);
    check_counters("csum_pkt");

    // Zero and oversize lengths.
    push_evt(1'b0, 2'b01);
    push_evt(1'b0, 2'b01);
    drive(1'b1, 32'hFB000000);
    drive(1'b1, 32'hFB000011);
    @(posedge clock4); #1;
    check("len_err", 64'({err, err_code, pkt_valid}), 64'(4'b1010));
    drive(1'b0, 32'h0);
    check_counters("len_err");

    // Timeout after one payload word of a two-word packet.
    exp_words.push_back({16'hAAAA, 1'b1, 1'b0, 32'h0BADF00D});
    push_evt(1'b0, 2'b11);
    drive(1'b1, 32'hFBAAAA02);
    drive(1'b1, 32'h0BADF00D);
    for (int k = 0; k < TIMEOUT; k++) begin
      drive(1'b0, 32'h0);
      @(posedge clock4); #1;
      if (k < TIMEOUT - 1) check("no_early_timeout", 64'(err), 64'd0);
      else                 check("timeout_err", 64'({err, err_code, pkt_eop}), 64'(4'b1110));
    end
    send_packet(16'hC0DE, 2, 1'b1, 0);
    check_counters("after_timeout");

    // Reset in the middle of a packet.
    w = 32'hFEEDBEEF;
    exp_words.push_back({16'h5555, 1'b1, 1'b0, w});
    drive(1'b1, 32'hFB555502);
    drive(1'b1, w);
    @(posedge clock4); #1;
    check("pre_reset_word", 64'(pkt_valid), 64'd1);
    @(negedge clock4);
    valid_in = 1'b0;
    #2;
    reset_L = 1'b0;
    #1;
    check("midrst_outputs_a", 64'({pkt_data, pkt_valid, pkt_sop, pkt_eop, done, err, err_code}), 64'd0);
    check("midrst_outputs_b", 64'({pkt_tag, good_cnt, err_cnt}), 64'd0);
    exp_words.delete();
    exp_evt.delete();
    exp_good = 0;
    exp_err  = 0;
    @(negedge clock4);
    reset_L = 1'b1;
    send_packet(16'h0102, 2, 1'b1, 0);
    check_counters("after_reset");

    // Randomized traffic with idle gaps, junk words and some bad frames.
    for (int p = 0; p < 30; p++) begin
      junk(int'($urandom_range(2, 0)));
      r = int'($urandom_range(9, 0));
      if (r == 0) begin
        len = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(255, MAX_LEN + 1));
        send_packet(16'($urandom), len, 1'b0, 0);
      end else begin
        len = int'($urandom_range(MAX_LEN, 1));
        send_packet(16'($urandom), len, (r > 1), TIMEOUT - 1);
      end
    end
    send_packet(16'hF00D, MAX_LEN, 1'b1, TIMEOUT - 1);
    check_counters("random");

    // Counter saturation.
    for (int p = 0; p < 260; p++) send_packet(16'($urandom), 1, 1'b1, 0);
    for (int p = 0; p < 260; p++) send_packet(16'($urandom), 0, 1'b0, 0);
    check_counters("saturate");

    gap(5);
    check("words_left", 64'(exp_words.size()), 64'd0);
    check("events_left", 64'(exp_evt.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/phy_rx_deframer.md
PHY_RX_DEFRAMER -- requirements
Module: phy_rx_deframer

Interface
REQ-001 Parameter MAX_LEN, default 16: maximum payload words per packet.
REQ-002 Parameter TIMEOUT, default 8: consecutive idle (valid low) cycles mid-packet before abort.
REQ-003 Clocking: one clock, clock4; reset_L is asynchronous, active-low.
REQ-004 clock4  input  1  sole clock; the block samples phy data_out/v4 on its rising edge.
REQ-005 reset_L  input  1  asynchronous active-low reset.
REQ-006 data_in  input  32  word stream from phy data_out.
REQ-007 valid_in  input  1  data_in qualifier, driven by phy v4.
REQ-008 pkt_data  output  32  registered payload word.
REQ-009 pkt_valid  output  1  pkt_data qualifier.
REQ-010 pkt_sop  output  1  high with the first payload word.
REQ-011 pkt_eop  output  1  high with the last payload word.
REQ-012 pkt_tag  output  16  tag of the current packet, held until the next header.
REQ-013 done  output  1  one-cycle pulse: packet passed its checksum.
REQ-014 err  output  1  one-cycle pulse: packet rejected.
REQ-015 err_code  output  2  01 bad length, 10 checksum mismatch, 11 timeout; held until the next err.
REQ-016 good_cnt, err_cnt  output  8 each  saturating event counters.

Function
REQ-017 Frame format: header word {8'hFB, tag[15:0], len[7:0]}, then len payload words, then one check word equal to the XOR of all payload words.
REQ-018 FSM states: IDLE, PAYLOAD, CHECK; only valid_in-high cycles advance the FSM.
REQ-019 IDLE: a valid word with [31:24]!=8'hFB is discarded with no output.
REQ-020 IDLE, header with 1<=len<=MAX_LEN: latch tag and len, clear the XOR accumulator, go to PAYLOAD.
REQ-021 IDLE, header with len==0 or len>MAX_LEN: err pulse with code 01 next cycle, err_cnt+1, stay in IDLE.
REQ-022 PAYLOAD: each valid word appears on pkt_data with pkt_valid one cycle later (latency 1) and is XORed into the accumulator.
REQ-023 PAYLOAD: the remaining count decrements per word; the last word asserts pkt_eop and the FSM goes to CHECK; len==1 asserts pkt_sop and pkt_eop together.
REQ-024 PAYLOAD: a word with [31:24]==8'hFB is payload, not a new header.
REQ-025 CHECK: a valid word equal to the accumulator gives a done pulse next cycle and good_cnt+1; otherwise an err pulse with code 10 and err_cnt+1; both cases return to IDLE.
REQ-026 PAYLOAD/CHECK: an idle counter counts valid_in-low cycles and clears on any valid word; reaching TIMEOUT gives an err pulse with code 11, err_cnt+1, and a return to IDLE with no pkt_eop.
REQ-027 Payload already forwarded is not retracted; the consumer discards a packet lacking done.
REQ-028 Counters saturate at 8'hFF.
REQ-029 done and err are never high in the same cycle; pkt_valid is low whenever the FSM is outside PAYLOAD output cycles.

Reset
REQ-030 On reset_L low, immediately: state IDLE; pkt_data 0; pkt_valid, pkt_sop, pkt_eop, done, err 0; pkt_tag 0; err_code 00; good_cnt, err_cnt, accumulator, and idle and remaining counters 0.
REQ-031 Reset asserted mid-packet abandons the packet with no err pulse; the first header after release starts cleanly.

Structure
REQ-032 Shared header deframer_defs.vh holds SOP 8'hFB, the state encodings, the err_code values, and the MAX_LEN and TIMEOUT defaults.
REQ-033 Sub-module xor_acc (32-bit XOR accumulator with clear and enable) is instantiated once; the rest is one FSM plus counters.
REQ-034 All outputs are registered; there is no combinational path from data_in to any output.

Verification
REQ-035 Header 32'hFB123403, payload 11111111/22222222/44444444, check 77777777 -> three pkt_valid cycles with sop on the first word and eop on the third, pkt_tag 1234, done pulse, good_cnt 1.
REQ-036 Same packet with check 77777770 -> payload forwarded, err pulse, err_code 10, err_cnt 1, done never high.
REQ-037 Headers FB000000 and FB000011 -> two err pulses with code 01, no pkt_valid, FSM stays in IDLE.
REQ-038 Header FBAAAA02, one payload word, then valid_in low for 8 cycles -> err code 11 on the 8th idle cycle, no eop; the following good packet gives done.
REQ-039 Header len 2, reset_L pulsed low after the first payload word -> all outputs 0 immediately, no err; the next good packet gives done and good_cnt 1.
REQ-040 Random valid_in gaps under 8 cycles within a 16-word packet -> the output word sequence matches the input, eop on word 16, done pulse.
